// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional-rate clock-enable generator.
package frac_clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } cfg_state_e;

    // Phase increment for f_out from f_ref with an acc_w-bit accumulator, rounded to nearest.
    function automatic logic [63:0] inc_from_freq(
        input longint unsigned f_ref_hz,
        input longint unsigned f_out_hz,
        input int unsigned     acc_w
    );
        logic [63:0] num;
        num = (64'(f_out_hz) << acc_w) + 64'(f_ref_hz / 64'd2);
        return num / 64'(f_ref_hz);
    endfunction

    // 25.2 MHz VGA pixel enable from a 50 MHz reference.
    localparam logic [31:0] VGA_25M2_INC =
        32'(inc_from_freq(64'd50_000_000, 64'd25_200_000, 32));

endpackage

// File: rtl/frac_clk_ch.sv
// One DDS channel: phase accumulator, lock counter and registered tick/square/locked outputs.
module frac_clk_ch #(
    parameter int unsigned       ACC_W      = 32,
    parameter int unsigned       LOCK_TICKS = 16,
    parameter logic [ACC_W-1:0]  INIT_INC   = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             apply_i,
    input  logic [ACC_W-1:0] new_inc_i,
    output logic             tick_o,
    output logic             clk_sq_o,
    output logic             locked_o,
    output logic [ACC_W-1:0] inc_o,
    output logic             carry_c_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_TICKS + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             locked_q, locked_d;
    logic [ACC_W:0]   sum_c;

    // Accumulator sum with carry; the carry is the raw overflow seen by the config FSM.
    always_comb begin
        sum_c     = {1'b0, acc_q} + {1'b0, inc_q};
        carry_c_o = sum_c[ACC_W];
    end

    // Next state: free-running accumulate, or restart from zero with the new increment.
    always_comb begin
        acc_d    = sum_c[ACC_W-1:0];
        inc_d    = inc_q;
        tick_d   = sum_c[ACC_W];
        sq_d     = sum_c[ACC_W-1];
        cnt_d    = cnt_q;
        locked_d = (cnt_q == CNT_W'(LOCK_TICKS)) && (inc_q != '0);
        if (sum_c[ACC_W] && (cnt_q != CNT_W'(LOCK_TICKS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (apply_i) begin
            acc_d    = '0;
            inc_d    = new_inc_i;
            tick_d   = 1'b0;
            sq_d     = 1'b0;
            cnt_d    = '0;
            locked_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            inc_q    <= INIT_INC;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            locked_q <= locked_d;
        end
    end

    assign tick_o   = tick_q;
    assign clk_sq_o = sq_q;
    assign locked_o = locked_q;
    assign inc_o    = inc_q;

endmodule

// File: rtl/frac_clk_gen.sv
// NUM_CH fractional-rate clock enables on refclk with a shared runtime reconfiguration port.
module frac_clk_gen
    import frac_clk_pkg::*;
#(
    parameter int unsigned      NUM_CH      = 2,
    parameter int unsigned      ACC_W       = 32,
    parameter logic [ACC_W-1:0] INIT_INC    = ACC_W'(VGA_25M2_INC),
    parameter int unsigned      LOCK_TICKS  = 16,
    parameter bit               SYNC_UPDATE = 1'b1,
    localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_sq,
    output logic [NUM_CH-1:0] locked
);

    cfg_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ACC_W-1:0]  inc_lat_q, inc_lat_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [NUM_CH-1:0] carry_c;
    logic [NUM_CH-1:0] apply_c;
    logic [ACC_W-1:0]  ch_inc [NUM_CH];
    logic              tgt_zero_c;
    logic              tgt_carry_c;

    // Look up the requested channel's increment and the latched channel's carry; out-of-range
    // requests look like a disabled channel so they pass straight through APPLY untouched.
    always_comb begin
        tgt_zero_c  = 1'b1;
        tgt_carry_c = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) tgt_zero_c = (ch_inc[i] == '0);
            if (ch_q == CH_W'(i))   tgt_carry_c = carry_c[i];
        end
    end

    // Config FSM state and request latch registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            inc_lat_q   <= '0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            inc_lat_q   <= inc_lat_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Next state: accept in IDLE, wait for the target's carry in PENDING, single-cycle APPLY.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        inc_lat_d = inc_lat_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    ch_d      = cfg_ch;
                    inc_lat_d = cfg_inc;
                    state_d   = (!SYNC_UPDATE || tgt_zero_c) ? APPLY : PENDING;
                end
            end
            PENDING: begin
                if (tgt_carry_c) state_d = APPLY;
            end
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready follows the upcoming state; apply strobes only the latched channel.
    always_comb begin
        cfg_ready_d = (state_d == IDLE);
        apply_c     = '0;
        if (state_q == APPLY) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_W'(i)) apply_c[i] = 1'b1;
            end
        end
    end

    assign cfg_ready = cfg_ready_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        frac_clk_ch #(
            .ACC_W      (ACC_W),
            .LOCK_TICKS (LOCK_TICKS),
            .INIT_INC   (INIT_INC)
        ) u_ch (
            .clk_i     (refclk),
            .rst_ni    (rst_n),
            .apply_i   (apply_c[g]),
            .new_inc_i (inc_lat_q),
            .tick_o    (tick[g]),
            .clk_sq_o  (clk_sq[g]),
            .locked_o  (locked[g]),
            .inc_o     (ch_inc[g]),
            .carry_c_o (carry_c[g])
        );
    end

endmodule

// File: tb/tb_frac_clk_gen.sv
module tb_frac_clk_gen;

    logic        refclk = 1'b0;
    logic        rst_n;

    logic        a_valid, a_ready;
    logic [0:0]  a_ch;
    logic [31:0] a_inc;
    logic [1:0]  a_tick, a_sq, a_locked;

    logic        s_valid, s_ready;
    logic [1:0]  s_ch;
    logic [31:0] s_inc;
    logic [2:0]  s_tick, s_sq, s_locked;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    frac_clk_gen #(.NUM_CH(2), .ACC_W(32), .LOCK_TICKS(16), .SYNC_UPDATE(1'b0)) u_dut_a (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_ch(a_ch), .cfg_inc(a_inc), .tick(a_tick), .clk_sq(a_sq), .locked(a_locked)
    );

    frac_clk_gen #(.NUM_CH(3), .ACC_W(32), .LOCK_TICKS(16), .SYNC_UPDATE(1'b1)) u_dut_s (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(s_valid), .cfg_ready(s_ready),
        .cfg_ch(s_ch), .cfg_inc(s_inc), .tick(s_tick), .clk_sq(s_sq), .locked(s_locked)
    );

    typedef struct {
        logic [31:0] inc;
        int          first;
        int          ticks;
        logic        lck;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt [5];
        int t16 [5];
        int tl  [5];
        logic [4:0] tk, lk;
        int first, nt, bad, trig, n, nl, ns, acc_cnt;
        logic l1_lost;

        // inc, first tick sample after apply, ticks in 80 samples, locked at sample 80
        vecs[0] = '{32'h8000_0000,  2, 40, 1'b1};
        vecs[1] = '{32'h4000_0000,  4, 20, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF,  2, 79, 1'b1};
        vecs[3] = '{32'h1000_0000, 16,  5, 1'b0};
        vecs[4] = '{32'hC000_0000,  2, 60, 1'b1};
        vecs[5] = '{32'h5555_5555,  4, 26, 1'b1};
        vecs[6] = '{32'h0000_0000,  0,  0, 1'b0};

        rst_n = 1'b0;
        a_valid = 1'b0; a_ch = '0; a_inc = '0;
        s_valid = 1'b0; s_ch = '0; s_inc = '0;

        // Reset state
        #12;
        check("rst_a_tick", a_tick, 0);
        check("rst_a_sq", a_sq, 0);
        check("rst_a_locked", a_locked, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_s_tick", s_tick, 0);
        check("rst_s_sq", s_sq, 0);
        check("rst_s_locked", s_locked, 0);
        check("rst_s_ready", s_ready, 1);
        #11;
        rst_n = 1'b1;

        // Test 1: INIT_INC rate and lock timing on all five channels
        for (int c = 0; c < 5; c++) begin cnt[c] = 0; t16[c] = 0; tl[c] = 0; end
        for (int k = 1; k <= 10000; k++) begin
            step();
            tk = {s_tick, a_tick};
            lk = {s_locked, a_locked};
            for (int c = 0; c < 5; c++) begin
                if (tk[c]) begin
                    cnt[c]++;
                    if (cnt[c] == 16) t16[c] = k;
                end
                if (lk[c] && tl[c] == 0) tl[c] = k;
            end
        end
        for (int c = 0; c < 5; c++) begin
            check_range($sformatf("t1_ticks_ch%0d", c), cnt[c], 5039, 5041);
            check($sformatf("t1_tick16_ch%0d", c), t16[c], 32);
            check($sformatf("t1_lock_rise_ch%0d", c), tl[c], 33);
        end

        // Test 2: immediate-update instance, table of increments on ch0
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1; a_ch = 1'b0; a_inc = vecs[i].inc;
            check($sformatf("t2_ready_pre_%0d", i), a_ready, 1);
            step();
            a_valid = 1'b0;
            check($sformatf("t2_ready_apply_%0d", i), a_ready, 0);
            step();
            check($sformatf("t2_ready_back_%0d", i), a_ready, 1);
            check($sformatf("t2_lock_drop_%0d", i), a_locked[0], 0);
            first = 0; nt = 0; l1_lost = 1'b0;
            for (int k = 1; k <= 80; k++) begin
                step();
                if (a_tick[0]) begin
                    nt++;
                    if (first == 0) first = k;
                end
                if (!a_locked[1]) l1_lost = 1'b1;
            end
            check($sformatf("t2_first_%0d", i), first, vecs[i].first);
            check($sformatf("t2_ticks_%0d", i), nt, vecs[i].ticks);
            check($sformatf("t2_locked_%0d", i), a_locked[0], vecs[i].lck);
            check($sformatf("t2_ch1_lost_%0d", i), l1_lost, 0);
        end

        // Test 3: synchronous update of ch1 to period 4
        s_valid = 1'b1; s_ch = 2'd1; s_inc = 32'h4000_0000;
        check("t3_ready_pre", s_ready, 1);
        step();
        s_valid = 1'b0;
        check("t3_ready_pending", s_ready, 0);
        trig = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (s_tick[1]) begin trig = k; break; end
        end
        check_range("t3_trigger_delay", trig, 1, 3);
        check("t3_ready_at_trigger", s_ready, 0);
        step();
        check("t3_ready_after_apply", s_ready, 1);
        check("t3_tick_apply", s_tick[1], 0);
        check("t3_lock_drop", s_locked[1], 0);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (s_tick[1] !== (k % 4 == 0)) bad++;
        end
        check("t3_period4_bad", bad, 0);
        check("t3_others_locked", {s_locked[2], s_locked[0]}, 2'b11);

        // Test 4: disable ch0, then re-enable; re-enable bypasses PENDING
        s_valid = 1'b1; s_ch = 2'd0; s_inc = 32'h0;
        step();
        s_valid = 1'b0;
        n = 0;
        while (!s_ready && n < 10) begin step(); n++; end
        check_range("t4_pending_len", n, 2, 4);
        nt = 0; nl = 0; ns = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (s_tick[0]) nt++;
            if (s_locked[0]) nl++;
            if (s_sq[0]) ns++;
        end
        check("t4_off_ticks", nt, 0);
        check("t4_off_locked", nl, 0);
        check("t4_off_sq", ns, 0);
        s_valid = 1'b1; s_ch = 2'd0; s_inc = 32'h8000_0000;
        step();
        s_valid = 1'b0;
        check("t4_ready_apply", s_ready, 0);
        step();
        check("t4_immediate", s_ready, 1);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (s_tick[0] !== (k % 2 == 0)) bad++;
        end
        check("t4_period2_bad", bad, 0);

        // Test 5: held cfg_valid with an out-of-range channel
        for (int k = 0; k < 40; k++) step();
        check("t5_locked_pre", s_locked, 3'b111);
        s_valid = 1'b1; s_ch = 2'd3; s_inc = 32'h1000_0000;
        acc_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (s_valid && s_ready) acc_cnt++;
            step();
        end
        s_valid = 1'b0;
        check("t5_accepts", acc_cnt, 2);
        step(); step();
        check("t5_locked_post", s_locked, 3'b111);
        nt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_tick[1]) nt++;
        end
        check("t5_ch1_ticks", nt, 10);

        // Test 6: asynchronous reset while an update is pending
        s_valid = 1'b1; s_ch = 2'd1; s_inc = 32'h1000_0000;
        step();
        s_valid = 1'b0;
        check("t6_pending", s_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tick", s_tick, 0);
        check("t6_rst_sq", s_sq, 0);
        check("t6_rst_locked", s_locked, 0);
        check("t6_rst_ready", s_ready, 1);
        check("t6_rst_a_locked", a_locked, 0);
        step();
        @(negedge refclk);
        rst_n = 1'b1;
        nt = 0; t16[0] = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (s_tick[1]) begin
                nt++;
                if (nt == 16) t16[0] = k;
            end
        end
        check("t6_ch1_ticks", nt, 503);
        check("t6_ch1_tick16", t16[0], 32);
        check("t6_ch1_locked", s_locked[1], 1);
        check("t6_ready", s_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
